// File: rtl/sipo_pkg.sv
// Shared constants and types for the sipo_reg serial-to-parallel capture stage.
// The PAR state is only reachable when SIPO_REG_PARITY_EN is defined.
package sipo_pkg;

  localparam int SIPO_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;

  // Observation point for externally bound checkers (count zero-extended to 5 bits).
  typedef struct packed {
    state_t     state;
    logic [4:0] cnt;
  } sipo_dbg_t;

  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_bitcnt.sv
// Modulo-WIDTH bit counter: synchronous active-low reset, synchronous clear, enable.
// tc_o flags the last bit position (cnt == WIDTH-1); the next enabled edge wraps to 0.
module sipo_bitcnt import sipo_pkg::*; #(
  parameter int WIDTH = SIPO_WIDTH_DEF,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             nr,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == CNT_W'(WIDTH - 1));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_reg.sv
// Serial-in/parallel-out word assembler with a one-cycle valid pulse per word.
// Define SIPO_REG_PARITY_EN to expect a trailing even-parity strobe after each word.
module sipo_reg import sipo_pkg::*; #(
  parameter int WIDTH     = SIPO_WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             nr,
  input  logic             clr,
  input  logic             en,
  input  logic             sin,
  output logic [WIDTH-1:0] pout,
  output logic             valid,
  output logic             busy,
  output logic             perr
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, shifted;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             valid_q, valid_d;
  logic             cnt_en, cnt_tc;
  logic [CNT_W-1:0] bit_cnt;
  sipo_dbg_t        unused_dbg;
`ifdef SIPO_REG_PARITY_EN
  logic             perr_q, perr_d;
`endif

  sipo_bitcnt #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_bitcnt (
    .clk  (clk),
    .nr   (nr),
    .clr  (clr),
    .en   (cnt_en),
    .cnt_o(bit_cnt),
    .tc_o (cnt_tc)
  );

  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {shreg_q[WIDTH-2:0], sin};
    end else begin : g_lsb
      assign shifted = {sin, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  // Priority: clr over en; nr is handled in the register process below.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    pout_d  = pout_q;
    valid_d = 1'b0;
    cnt_en  = 1'b0;
`ifdef SIPO_REG_PARITY_EN
    perr_d  = perr_q;
`endif
    if (clr) begin
      state_d = ST_IDLE;
      shreg_d = '0;
    end else if (en) begin
      case (state_q)
        ST_IDLE: begin
          shreg_d = shifted;
          cnt_en  = 1'b1;
          state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          shreg_d = shifted;
          cnt_en  = 1'b1;
          if (cnt_tc) begin
`ifdef SIPO_REG_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_IDLE;
            pout_d  = shifted;
            valid_d = 1'b1;
`endif
          end
        end
`ifdef SIPO_REG_PARITY_EN
        ST_PAR: begin
          // Even parity: data ones plus the parity bit must total an even count.
          state_d = ST_IDLE;
          pout_d  = shreg_q;
          valid_d = 1'b1;
          perr_d  = (^shreg_q) ^ sin;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nr) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      pout_q  <= '0;
      valid_q <= 1'b0;
`ifdef SIPO_REG_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      pout_q  <= pout_d;
      valid_q <= valid_d;
`ifdef SIPO_REG_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign unused_dbg = '{state: state_q, cnt: 5'(bit_cnt)};

  assign pout  = pout_q;
  assign valid = valid_q;
  assign busy  = (state_q != ST_IDLE);
`ifdef SIPO_REG_PARITY_EN
  assign perr  = perr_q;
`else
  assign perr  = 1'b0;
`endif

endmodule
